imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Shares the single combinational InstructionMemory read port between two requesters:
  - the CPU fetch stage (port F);
  - the debug/program-inspection reader (port D).
- Fixed priority to F, with a starvation guard that forces a D grant.
- Sequences each granted read through a parameterised registered response pipeline.
- Supports flushing in-flight fetch responses on a branch redirect.
- Sits between the PC/fetch logic and InstructionMemory.

Parameters:
- READ_LATENCY, 1: cycles from grant to response valid; legal 1..4.
- STARVE_LIMIT, 4: consecutive F grants while D is pending before D is forced; legal 1..15.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Fetch_Req  input  1  F read request.
- Fetch_Addr  input  32  F address.
- Fetch_Gnt  output  1  F request accepted this cycle.
- Fetch_Flush  input  1  discard all in-flight F responses.
- Fetch_Valid  output  1  F response valid, one-cycle pulse.
- Fetch_Instr  output  32  F response data.
- Dbg_Req  input  1  D read request.
- Dbg_Addr  input  32  D address.
- Dbg_Gnt  output  1  D request accepted this cycle.
- Dbg_Valid  output  1  D response valid, one-cycle pulse.
- Dbg_Instr  output  32  D response data.
- Mem_Address  output  32  to InstructionMemory Address.
- Mem_Instruction  input  32  from InstructionMemory Instruction.

Behaviour:
- Reset:
  - Clk and Rst_n only; Rst_n is asynchronous, active-low.
  - Reset clears all pipeline stages, valids, response data (to 0), the starvation counter and the arbiter state.
  - Asserting reset mid-transaction drops all in-flight reads; no Valid after reset deassertion for reads granted before reset.
- Grant:
  - Combinational, at most one per cycle; Fetch_Gnt and Dbg_Gnt are mutually exclusive.
  - Mem_Address = granted requester's address; 0 when no grant.
- Arbiter FSM:
  - PRI_F:
    - F wins if Fetch_Req; else D wins if Dbg_Req.
    - On an F grant with Dbg_Req high, StarveCnt increments.
    - When StarveCnt reaches STARVE_LIMIT, go to FORCE_D.
    - Any D grant clears StarveCnt.
  - FORCE_D:
    - D granted if Dbg_Req, regardless of Fetch_Req.
    - Then return to PRI_F with StarveCnt = 0.
    - If Dbg_Req drops, return to PRI_F without granting and clear StarveCnt.
- Pipeline:
  - Mem_Instruction is captured at the grant-cycle edge into stage 1, tagged with owner (F/D).
  - Stages shift every cycle; no backpressure.
  - Response visible on the owner's Valid/Instr in cycle t+READ_LATENCY, where t is the grant cycle.
  - Throughput is one read per cycle; in-order responses.
- Response outputs:
  - Instr holds the last delivered value while Valid is low.
  - The non-owner's outputs are unchanged.
- Flush:
  - Fetch_Flush clears the valid bit of every F-tagged stage, including the stage that would present this cycle.
  - Fetch_Valid is 0 in a flush cycle.
  - A F grant issued in the same cycle as flush is NOT flushed; it carries the redirect address.
  - D-tagged entries are unaffected.
- Simultaneous requests:
  - In PRI_F, F wins.
  - Requests are level-held until granted; a requester may change its address only after Gnt.

Optional Feature:
- IMEM_ARB_STATS_EN defined:
  - Adds outputs Stat_FetchGrants[31:0], Stat_DbgGrants[31:0] and Stat_ForceCount[15:0].
  - Stat_ForceCount counts FORCE_D grants.
  - All counters are saturating and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg holds:
  - owner enum OWN_F=0/OWN_D=1;
  - arbiter state enum PRI_F/FORCE_D;
  - INSTR_W=32 and ADDR_W=32 constants;
  - the pipeline-stage struct {valid, owner, data}.
- One sub-module, imem_resp_pipe: the READ_LATENCY-deep tagged shift pipeline with owner-selective flush.

Test Plan:
- F-only stream at addresses 0..10 every cycle, READ_LATENCY=1:
  - Fetch_Gnt is high every cycle;
  - Fetch_Valid is high from cycle 1;
  - Fetch_Instr equals the memory word for address k in cycle k+1.
- F and D both held high, STARVE_LIMIT=4:
  - grants F,F,F,F,D,F,F,F,F,D;
  - Dbg_Valid one cycle after each D grant.
- READ_LATENCY=3:
  - F granted addresses 4, 5, 6, then Fetch_Flush in the cycle after granting 6, with a grant to address 20 in the same cycle;
  - no Valid for 4, 5 or 6; Valid for 20 three cycles after its grant.
- D read of address 3 in flight plus a flush during its latency:
  - Dbg_Valid still fires with the word at address 3.
- Rst_n pulled low asynchronously mid-stream with 2 reads in flight:
  - all Valid, Gnt-related state and Instr outputs go to 0 immediately;
  - no stale Valid after release.
- IMEM_ARB_STATS_EN defined, after the test-2 sequence:
  - Stat_FetchGrants=8, Stat_DbgGrants=2, Stat_ForceCount=2.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
//   owner_e     : response owner tag (fetch / debug)
//   arb_state_e : arbiter state
//   stage_t     : one response-pipeline stage {valid, owner, data}
package imem_arb_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    PRI_F   = 1'b0,
    FORCE_D = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               valid;
    owner_e             owner;
    logic [INSTR_W-1:0] data;
  } stage_t;

  // Drops a fetch-owned entry when a flush is active; debug entries pass through.
  function automatic stage_t flush_kill(input stage_t s, input logic flush_f);
    stage_t r;
    r = s;
    if (flush_f && (s.owner == OWN_F)) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Bus bundle between fetch/debug requesters, the arbiter and InstructionMemory.
//   fetch_* : fetch-stage request, grant, flush and response
//   dbg_*   : debug-reader request, grant and response
//   mem_*   : InstructionMemory address out / instruction in
//   stat_*  : grant statistics, present only with IMEM_ARB_STATS_EN
// Modports: slave = arbiter view, master = requester/memory view.
interface imem_fetch_arbiter_if;
  import imem_arb_pkg::*;

  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_gnt;
  logic               fetch_flush;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               dbg_req;
  logic [ADDR_W-1:0]  dbg_addr;
  logic               dbg_gnt;
  logic               dbg_valid;
  logic [INSTR_W-1:0] dbg_instr;
  logic [ADDR_W-1:0]  mem_address;
  logic [INSTR_W-1:0] mem_instruction;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]        stat_fetch_grants;
  logic [31:0]        stat_dbg_grants;
  logic [15:0]        stat_force_count;
`endif

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush, dbg_req, dbg_addr, mem_instruction,
`ifdef IMEM_ARB_STATS_EN
    output stat_fetch_grants, stat_dbg_grants, stat_force_count,
`endif
    output fetch_gnt, fetch_valid, fetch_instr, dbg_gnt, dbg_valid, dbg_instr, mem_address
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush, dbg_req, dbg_addr, mem_instruction,
`ifdef IMEM_ARB_STATS_EN
    input  stat_fetch_grants, stat_dbg_grants, stat_force_count,
`endif
    input  fetch_gnt, fetch_valid, fetch_instr, dbg_gnt, dbg_valid, dbg_instr, mem_address
  );

endinterface

// File: rtl/imem_resp_pipe.sv
// Owner-tagged response shift pipeline, DEPTH stages, no backpressure.
//   clk, rst_n : clock, async active-low reset
//   in_stage   : entry captured into stage 0 at every edge (the grant-cycle read)
//   flush_f    : clears every fetch-owned stage, including the one presenting now
//   tail_c     : last stage, flush-gated (combinational)
module imem_resp_pipe
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in_stage,
  input  logic   flush_f,
  output stage_t tail_c
);

  stage_t stg_q [DEPTH];

  // A new entry enters unflushed: a grant in a flush cycle carries the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= in_stage;
      for (int unsigned i = 1; i < DEPTH; i++) stg_q[i] <= flush_kill(stg_q[i-1], flush_f);
    end
  end

  assign tail_c = flush_kill(stg_q[DEPTH-1], flush_f);

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single InstructionMemory read port between fetch (F, fixed
// priority) and debug (D, starvation-guarded), and returns each read through a
// READ_LATENCY-deep tagged pipeline with fetch-only flush.
//   clk, rst_n : clock, async active-low reset
//   bus        : imem_fetch_arbiter_if.slave (requests, grants, responses, memory)
// Optional: IMEM_ARB_STATS_EN adds saturating grant/force counters on bus.stat_*.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_fetch_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               gnt_f, gnt_d;
  stage_t             in_stage, tail;
  logic               f_vld, d_vld;
  logic [INSTR_W-1:0] f_hold_q, d_hold_q;

  // Arbiter state and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI_F;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count F wins over a waiting D, force D once the limit is hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PRI_F: begin
        if (bus.fetch_req) begin
          if (bus.dbg_req) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LIMIT) state_d = FORCE_D;
          end
        end else if (bus.dbg_req) begin
          cnt_d = '0;
        end
      end
      FORCE_D: begin
        state_d = PRI_F;
        cnt_d   = '0;
      end
      default: begin
        state_d = PRI_F;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant and memory address decode.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    case (state_q)
      PRI_F: begin
        gnt_f = bus.fetch_req;
        gnt_d = !bus.fetch_req && bus.dbg_req;
      end
      FORCE_D: gnt_d = bus.dbg_req;
      default: ;
    endcase
  end

  assign bus.fetch_gnt   = gnt_f;
  assign bus.dbg_gnt     = gnt_d;
  assign bus.mem_address = gnt_f ? bus.fetch_addr :
                           gnt_d ? bus.dbg_addr   : '0;

  always_comb begin
    in_stage.valid = gnt_f || gnt_d;
    in_stage.owner = gnt_d ? OWN_D : OWN_F;
    in_stage.data  = bus.mem_instruction;
  end

  imem_resp_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_stage (in_stage),
    .flush_f  (bus.fetch_flush),
    .tail_c   (tail)
  );

  assign f_vld = tail.valid && (tail.owner == OWN_F);
  assign d_vld = tail.valid && (tail.owner == OWN_D);

  // Last delivered word per owner, shown while that owner's valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (f_vld) f_hold_q <= tail.data;
      if (d_vld) d_hold_q <= tail.data;
    end
  end

  assign bus.fetch_valid = f_vld;
  assign bus.dbg_valid   = d_vld;
  assign bus.fetch_instr = f_vld ? tail.data : f_hold_q;
  assign bus.dbg_instr   = d_vld ? tail.data : d_hold_q;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] sfg_q, sdg_q;
  logic [15:0] sfc_q;

  // Saturating grant statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfg_q <= '0;
      sdg_q <= '0;
      sfc_q <= '0;
    end else begin
      if (gnt_f && (sfg_q != '1)) sfg_q <= sfg_q + 32'd1;
      if (gnt_d && (sdg_q != '1)) sdg_q <= sdg_q + 32'd1;
      if (gnt_d && (state_q == FORCE_D) && (sfc_q != '1)) sfc_q <= sfc_q + 16'd1;
    end
  end

  assign bus.stat_fetch_grants = sfg_q;
  assign bus.stat_dbg_grants   = sdg_q;
  assign bus.stat_force_count  = sfc_q;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench: two arbiters (READ_LATENCY 1 and 3) share one stimulus
// stream; a per-instance scoreboard holds expected responses keyed by due cycle.
module tb_imem_fetch_arbiter;
  import imem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        fetch_req, dbg_req, fetch_flush;
  logic [31:0] fetch_addr, dbg_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    owner_e      own;
    logic [31:0] data;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] last_f[2];
  logic [31:0] last_d[2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  imem_fetch_arbiter_if ifc1();
  imem_fetch_arbiter_if ifc3();

  assign ifc1.fetch_req       = fetch_req;
  assign ifc1.fetch_addr      = fetch_addr;
  assign ifc1.fetch_flush     = fetch_flush;
  assign ifc1.dbg_req         = dbg_req;
  assign ifc1.dbg_addr        = dbg_addr;
  assign ifc1.mem_instruction = mem_word(ifc1.mem_address);
  assign ifc3.fetch_req       = fetch_req;
  assign ifc3.fetch_addr      = fetch_addr;
  assign ifc3.fetch_flush     = fetch_flush;
  assign ifc3.dbg_req         = dbg_req;
  assign ifc3.dbg_addr        = dbg_addr;
  assign ifc3.mem_instruction = mem_word(ifc3.mem_address);

  imem_fetch_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1));
  imem_fetch_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(ifc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s c%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst1_fetch_valid", ifc1.fetch_valid, 0);
    chk("rst1_dbg_valid",   ifc1.dbg_valid,   0);
    chk("rst1_fetch_instr", ifc1.fetch_instr, 0);
    chk("rst1_dbg_instr",   ifc1.dbg_instr,   0);
    chk("rst1_gnt",         {ifc1.fetch_gnt, ifc1.dbg_gnt}, 0);
    chk("rst1_mem_address", ifc1.mem_address, 0);
    chk("rst3_fetch_valid", ifc3.fetch_valid, 0);
    chk("rst3_dbg_valid",   ifc3.dbg_valid,   0);
    chk("rst3_fetch_instr", ifc3.fetch_instr, 0);
    chk("rst3_dbg_instr",   ifc3.dbg_instr,   0);
    chk("rst3_gnt",         {ifc3.fetch_gnt, ifc3.dbg_gnt}, 0);
  endtask

  task automatic check_resp(input int w);
    exp_t        e;
    bit          has;
    logic        fv, dv;
    logic [31:0] fi, di;
    string       p;
    has = 0;
    if (w == 0) begin
      p = "rl1"; fv = ifc1.fetch_valid; dv = ifc1.dbg_valid;
      fi = ifc1.fetch_instr; di = ifc1.dbg_instr;
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1; end
    end else begin
      p = "rl3"; fv = ifc3.fetch_valid; dv = ifc3.dbg_valid;
      fi = ifc3.fetch_instr; di = ifc3.dbg_instr;
      if (q3.size() > 0 && q3[0].due == cyc) begin e = q3.pop_front(); has = 1; end
    end
    if (has && e.own == OWN_F) last_f[w] = e.data;
    if (has && e.own == OWN_D) last_d[w] = e.data;
    chk({p, "_fetch_valid"}, fv, 32'(has && e.own == OWN_F));
    chk({p, "_dbg_valid"},   dv, 32'(has && e.own == OWN_D));
    chk({p, "_fetch_instr"}, fi, last_f[w]);
    chk({p, "_dbg_instr"},   di, last_d[w]);
  endtask

  task automatic flush_q();
    exp_t k[$];
    foreach (q1[i]) if (q1[i].own != OWN_F) k.push_back(q1[i]);
    q1 = k;
    k.delete();
    foreach (q3[i]) if (q3[i].own != OWN_F) k.push_back(q3[i]);
    q3 = k;
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance to next posedge+1.
  task automatic step(input logic fr, input logic [31:0] fa, input logic dr,
                      input logic [31:0] da, input logic fl, input logic ef, input logic ed);
    logic [31:0] ea;
    fetch_req = fr; fetch_addr = fa; dbg_req = dr; dbg_addr = da; fetch_flush = fl;
    if (fl) flush_q();
    @(negedge clk);
    check_resp(0);
    check_resp(1);
    ea = ef ? fa : (ed ? da : 32'd0);
    chk("rl1_fetch_gnt", ifc1.fetch_gnt, 32'(ef));
    chk("rl1_dbg_gnt",   ifc1.dbg_gnt,   32'(ed));
    chk("rl1_mem_addr",  ifc1.mem_address, ea);
    chk("rl3_fetch_gnt", ifc3.fetch_gnt, 32'(ef));
    chk("rl3_dbg_gnt",   ifc3.dbg_gnt,   32'(ed));
    chk("rl3_mem_addr",  ifc3.mem_address, ea);
    if (ef || ed) begin
      q1.push_back('{cyc + 1, ed ? OWN_D : OWN_F, mem_word(ea)});
      q3.push_back('{cyc + 3, ed ? OWN_D : OWN_F, mem_word(ea)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] fa, da;
    bit          pat[10];
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 2; i++) begin last_f[i] = '0; last_d[i] = '0; end
    rst_n = 1'b0; fetch_req = 0; dbg_req = 0; fetch_flush = 0;
    fetch_addr = '0; dbg_addr = '0;
    #1;
    chk_zero();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Both held: starvation guard forces every fifth grant to D.
    fa = 100; da = 200;
    for (int i = 0; i < 10; i++) begin
      step(1, fa, 1, da, 0, !pat[i], pat[i]);
      if (pat[i]) da++; else fa++;
    end
    idle(1);
`ifdef IMEM_ARB_STATS_EN
    chk("stat_fetch_grants", ifc1.stat_fetch_grants, 8);
    chk("stat_dbg_grants",   ifc1.stat_dbg_grants,   2);
    chk("stat_force_count",  32'(ifc1.stat_force_count), 2);
`endif
    idle(3);

    // F-only back-to-back stream.
    for (int k = 0; k <= 10; k++) step(1, 32'(k), 0, 0, 0, 1, 0);
    idle(3);

    // Flush with a same-cycle redirect grant.
    step(1, 4, 0, 0, 0, 1, 0);
    step(1, 5, 0, 0, 0, 1, 0);
    step(1, 6, 0, 0, 0, 1, 0);
    step(1, 20, 0, 0, 1, 1, 0);
    idle(4);

    // Debug read survives a flush during its latency.
    step(1, 7, 0, 0, 0, 1, 0);
    step(0, 0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Asynchronous reset with reads in flight.
    step(1, 30, 0, 0, 0, 1, 0);
    step(1, 31, 0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0; fetch_req = 0; dbg_req = 0; fetch_flush = 0;
    #1;
    chk_zero();
    q1.delete(); q3.delete();
    for (int i = 0; i < 2; i++) begin last_f[i] = '0; last_d[i] = '0; end
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1; cyc++;
    idle(5);
    step(1, 40, 0, 0, 0, 1, 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
